// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data load/store.
// Serialises accesses as IDLE -> ACCESS (MEM_LAT+1 cycles) -> RESP and stalls the waiting stages.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              grant_data_reg;
    logic              last_data_reg;
    logic              kill_reg;
    logic              we_reg;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] dm_rdata_reg;

    logic any_req;
    logic grant_data;
    logic fetch_active;
    logic kill_now;
    logic capture;

    assign any_req      = if_req | dm_req;
    // Data has priority unless it won the previous grant and fetch is also waiting.
    assign grant_data   = dm_req & ~(if_req & last_data_reg);
    assign fetch_active = (state_reg != IDLE) & ~grant_data_reg;
    assign kill_now     = kill_reg | (fetch_active & if_kill);
    assign capture      = (state_reg == ACCESS) && (cnt_reg == 4'd0);

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        if_done    = 1'b0;
        dm_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) state_next = ACCESS;
            end
            ACCESS: begin
                mem_req = (cnt_reg == LAT);
                mem_we  = (cnt_reg == LAT) & we_reg;
                if (cnt_reg == 4'd0) state_next = RESP;
            end
            RESP: begin
                // A kill arriving in the response cycle itself still swallows the pulse.
                if_done    = ~grant_data_reg & ~kill_reg & ~if_kill;
                dm_done    = grant_data_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_data_reg <= 1'b0;
            last_data_reg  <= 1'b0;
            kill_reg       <= 1'b0;
            we_reg         <= 1'b0;
            cnt_reg        <= 4'd0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            if_rdata_reg   <= '0;
            dm_rdata_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_data_reg <= grant_data;
                        last_data_reg  <= grant_data;
                        cnt_reg        <= LAT;
                        mem_addr_reg   <= grant_data ? dm_addr : if_addr;
                        mem_wdata_reg  <= grant_data ? dm_wdata : '0;
                        we_reg         <= grant_data & dm_we;
                    end
                end
                ACCESS: begin
                    if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
                    if (capture) begin
                        if (grant_data_reg && !we_reg) dm_rdata_reg <= mem_rdata;
                        if (!grant_data_reg && !kill_now) if_rdata_reg <= mem_rdata;
                    end
                end
                default: ;
            endcase
            if (state_reg == RESP) kill_reg <= 1'b0;
            else if (fetch_active && if_kill) kill_reg <= 1'b1;
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a timestamp-based transaction model.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_done;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        stall_if;
    logic        stall_mem;

    int checks = 0;
    int failures = 0;
    int n = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h40) return 32'h20020005;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: answers each strobe exactly L cycles later, drives noise otherwise.
    logic        pend_v[0:L];
    logic [31:0] pend_a[0:L];
    initial begin
        for (int k = 0; k <= L; k++) begin
            pend_v[k] = 1'b0;
            pend_a[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                pend_v[L] = 1'b1;
                pend_a[L] = mem_addr;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < L; k++) begin
                pend_v[k] = pend_v[k+1];
                pend_a[k] = pend_a[k+1];
            end
            pend_v[L] = 1'b0;
            mem_rdata = pend_v[0] ? mem_data(pend_a[0]) : $urandom;
        end
    end

    // Reference model: one outstanding transaction described by its grant cycle.
    bit          m_busy = 0, m_data = 0, m_we = 0, m_killed = 0, m_last_data = 0;
    int          m_g = 0;
    int          m_txn = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
    initial begin
        int ph;
        bit e_req, e_we, e_ifd, e_dmd;
        forever begin
            @(negedge clk);
            ph    = m_busy ? (n - m_g) : 0;
            e_req = m_busy && ph == 1;
            e_we  = e_req && m_data && m_we;
            e_ifd = m_busy && ph == L + 2 && !m_data && !m_killed && !if_kill;
            e_dmd = m_busy && ph == L + 2 && m_data;
            chk1("mem_req", mem_req, e_req);
            chk1("mem_we", mem_we, e_we);
            chk1("if_done", if_done, e_ifd);
            chk1("dm_done", dm_done, e_dmd);
            chk1("stall_if", stall_if, if_req & ~e_ifd);
            chk1("stall_mem", stall_mem, dm_req & ~e_dmd);
            chk("if_rdata", if_rdata, m_if_rd);
            chk("dm_rdata", dm_rdata, m_dm_rd);
            chk("mem_addr", mem_addr, m_addr);
            if (m_busy && m_data) chk("mem_wdata", mem_wdata, m_wdata);

            if (reset) begin
                m_busy = 0; m_killed = 0; m_last_data = 0;
                m_if_rd = '0; m_dm_rd = '0; m_addr = '0; m_wdata = '0;
            end else if (m_busy) begin
                if (!m_data && if_kill) m_killed = 1;
                if (ph == L + 1) begin
                    if (m_data && !m_we) m_dm_rd = mem_data(m_addr);
                    else if (!m_data && !m_killed) m_if_rd = mem_data(m_addr);
                end
                if (ph == L + 2) begin
                    m_txn++;
                    $display("txn %0d %s addr=%h we=%0d killed=%0d end_cycle=%0d", m_txn,
                             m_data ? "data " : "fetch", m_addr, m_we, m_killed, n);
                    m_busy = 0;
                    m_killed = 0;
                end
            end else if (dm_req || if_req) begin
                m_data      = dm_req && !(if_req && m_last_data);
                m_last_data = m_data;
                m_busy      = 1;
                m_g         = n;
                m_addr      = m_data ? dm_addr : if_addr;
                m_wdata     = dm_wdata;
                m_we        = m_data && dm_we;
            end
            n++;
        end
    end

    // Stimulus with literal expectations for the directed scenarios.
    initial begin
        logic [31:0] prev;
        logic [31:0] got_addr[4];
        int          got_cyc[4];
        logic [31:0] exp_addr[4];
        int          exp_cyc[4];
        int          ng, done_cnt;
        bit          saw_if, saw_dm, if_pend, dm_pend;

        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset in the middle of a fetch.
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h40; end
            if (c == 2) reset = 1'b1;
            if (c == 3) begin reset = 1'b0; if_req = 1'b0; end
            @(negedge clk);
            if (c == 3) begin
                chk1("t1_mem_req", mem_req, 1'b0);
                chk("t1_if_rdata", if_rdata, 32'h0);
                chk("t1_mem_addr", mem_addr, 32'h0);
                chk("t1_mem_wdata", mem_wdata, 32'h0);
                chk1("t1_stall_if", stall_if, 1'b0);
            end
            if (c >= 3) chk1("t1_no_if_done", if_done, 1'b0);
        end
        $display("scenario reset-abort complete");

        // Lone fetch.
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h40; end
            if (c == 5) if_req = 1'b0;
            @(negedge clk);
            if (c == 0) chk1("t2_stall_c0", stall_if, 1'b1);
            if (c == 1) begin
                chk1("t2_mem_req", mem_req, 1'b1);
                chk("t2_mem_addr", mem_addr, 32'h40);
                chk1("t2_mem_we", mem_we, 1'b0);
            end
            if (c == 3) chk1("t2_stall_c3", stall_if, 1'b1);
            if (c == 4) begin
                chk1("t2_if_done", if_done, 1'b1);
                chk("t2_if_rdata", if_rdata, 32'h20020005);
                chk1("t2_stall_c4", stall_if, 1'b0);
            end
        end
        $display("scenario lone-fetch complete");

        // Simultaneous fetch and load straight after reset.
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        for (int c = 0; c < 11; c++) begin
            step();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h44;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
            end
            if (c == 5) dm_req = 1'b0;
            if (c == 10) if_req = 1'b0;
            @(negedge clk);
            if (c == 1) chk("t3_first_addr", mem_addr, 32'h100);
            if (c == 4) begin
                chk1("t3_dm_done", dm_done, 1'b1);
                chk("t3_dm_rdata", dm_rdata, mem_data(32'h100));
            end
            if (c == 6) begin
                chk1("t3_fetch_mem_req", mem_req, 1'b1);
                chk("t3_fetch_addr", mem_addr, 32'h44);
            end
            if (c == 8) chk1("t3_stall_c8", stall_if, 1'b1);
            if (c == 9) begin
                chk1("t3_if_done", if_done, 1'b1);
                chk("t3_if_rdata", if_rdata, mem_data(32'h44));
            end
        end
        $display("scenario simultaneous complete");

        // Store.
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin
                dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
            end
            if (c == 5) begin dm_req = 1'b0; dm_we = 1'b0; end
            @(negedge clk);
            if (c == 1) begin
                chk1("t4_mem_req", mem_req, 1'b1);
                chk1("t4_mem_we", mem_we, 1'b1);
                chk("t4_mem_addr", mem_addr, 32'h80);
            end
            if (c == 2) begin
                chk1("t4_mem_we_c2", mem_we, 1'b0);
                chk("t4_wdata_c2", mem_wdata, 32'hDEADBEEF);
            end
            if (c == 4) begin
                chk1("t4_dm_done", dm_done, 1'b1);
                chk("t4_wdata_c4", mem_wdata, 32'hDEADBEEF);
            end
            if (c == 5) chk("t4_dm_rdata_kept", dm_rdata, mem_data(32'h100));
        end
        $display("scenario store complete");

        // Alternation with both requesters continuously pending.
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        exp_addr = '{32'h1000, 32'h300, 32'h1004, 32'h304};
        exp_cyc  = '{1, 6, 11, 16};
        ng = 0; saw_if = 0; saw_dm = 0;
        for (int c = 0; c < 22; c++) begin
            step();
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h300;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1000;
            end else begin
                if (saw_dm) dm_addr = dm_addr + 32'd4;
                if (saw_if) if_addr = if_addr + 32'd4;
            end
            if (c == 20) begin if_req = 1'b0; dm_req = 1'b0; end
            @(negedge clk);
            saw_if = if_done;
            saw_dm = dm_done;
            if (mem_req === 1'b1) begin
                if (ng < 4) begin got_addr[ng] = mem_addr; got_cyc[ng] = c; end
                ng++;
            end
        end
        chk("t5_grant_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_grant%0d_addr", k), got_addr[k], exp_addr[k]);
            chk($sformatf("t5_grant%0d_cycle", k), 32'(got_cyc[k]), 32'(exp_cyc[k]));
        end
        $display("scenario alternation complete");

        // Kill of an in-flight fetch followed by a redirected fetch.
        prev = mem_data(32'h304);
        done_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            step();
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h40; end
            if (c == 2) if_kill = 1'b1;
            if (c == 3) begin if_kill = 1'b0; if_addr = 32'h200; end
            if (c == 10) if_req = 1'b0;
            @(negedge clk);
            if (c <= 5 && if_done === 1'b1) done_cnt++;
            if (c == 5) begin
                chk("t6_no_done", 32'(done_cnt), 32'd0);
                chk("t6_if_rdata_kept", if_rdata, prev);
            end
            if (c == 6) begin
                chk1("t6_redirect_req", mem_req, 1'b1);
                chk("t6_redirect_addr", mem_addr, 32'h200);
            end
            if (c == 9) begin
                chk1("t6_if_done", if_done, 1'b1);
                chk("t6_if_rdata", if_rdata, mem_data(32'h200));
            end
        end
        $display("scenario kill complete");

        // Randomized traffic, model-checked every cycle.
        if_pend = 0; dm_pend = 0; saw_if = 0; saw_dm = 0;
        for (int i = 0; i < 2500; i++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            if (reset) begin
                if_req = 1'b0; dm_req = 1'b0; if_pend = 0; dm_pend = 0;
            end else begin
                if (if_pend && saw_if) begin if_pend = 0; if_req = 1'b0; end
                if (dm_pend && saw_dm) begin dm_pend = 0; dm_req = 1'b0; end
                if (dm_pend && $urandom_range(0, 59) == 0) begin dm_pend = 0; dm_req = 1'b0; end
                if (!if_pend && $urandom_range(0, 2) == 0) begin
                    if_pend = 1; if_req = 1'b1; if_addr = 32'($urandom_range(0, 4095));
                end
                if (!dm_pend && $urandom_range(0, 2) == 0) begin
                    dm_pend = 1; dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                    dm_addr = 32'($urandom_range(0, 4095)); dm_wdata = $urandom;
                end
                if (if_pend && $urandom_range(0, 7) == 0) if_addr = 32'($urandom_range(0, 4095));
                if (dm_pend && $urandom_range(0, 7) == 0) dm_addr = 32'($urandom_range(0, 4095));
            end
            if_kill = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            saw_if = if_done;
            saw_dm = dm_done;
        end
        step();
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; if_kill = 1'b0;
        repeat (8) step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
